// File: rtl/xadc_drp_sampler.sv
// xadc_drp_sampler
//   Sits between the XADC DRP port and the threshold/compare logic. Each
//   end-of-conversion issues one DRP read of DADDR and waits for drdy. If
//   drdy does not arrive within TIMEOUT cycles the read is abandoned and a
//   timeout pulse is raised. The 12-bit result can be optionally averaged
//   over 2^AVG_LOG2 reads before it is presented as a one-cycle-valid sample.
//   End-of-conversion pulses that arrive while a read is in flight are
//   counted in drop_cnt, so lost conversions are visible to software.
//
// Parameters
//   DADDR     DRP address read on every request
//   AVG_LOG2  log2 of the averaging window (0..4, 0 = no averaging)
//   TIMEOUT   WAIT cycles allowed for drdy (1..255)
//
// Ports
//   clk           system clock / DRP dclk
//   rst           asynchronous active-high reset
//   eoc_in        end-of-conversion pulse from XADC
//   drdy_in       DRP data ready
//   do_in[15:0]   DRP read data, result in do_in[15:4]
//   den_out       DRP enable, one pulse per request
//   daddr_out     DRP address (constant DADDR)
//   avg_en        1 = averaged output, 0 = every raw sample
//   sample_out    latest raw or averaged result
//   sample_valid  one-cycle pulse when sample_out updates
//   timeout_err   one-cycle pulse on DRP timeout
//   drop_cnt      eoc pulses ignored while busy, saturating at 8'hFF
//   busy          high whenever a read is in flight
//
// Optional build macro XADC_SAMPLER_MINMAX_EN adds:
//   min_out / max_out  smallest / largest raw sample since reset or clear
//   minmax_clr         restores min_out=12'hFFF, max_out=12'h000 (wins over
//                      a simultaneous sample)

module xadc_drp_sampler #(
    parameter logic [6:0]  DADDR    = 7'h12,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eoc_in,
    input  logic        drdy_in,
    input  logic [15:0] do_in,
    output logic        den_out,
    output logic [6:0]  daddr_out,
    input  logic        avg_en,
    output logic [11:0] sample_out,
    output logic        sample_valid,
    output logic        timeout_err,
    output logic [7:0]  drop_cnt,
    output logic        busy
`ifdef XADC_SAMPLER_MINMAX_EN
    ,
    output logic [11:0] min_out,
    output logic [11:0] max_out,
    input  logic        minmax_clr
`endif
);

    localparam int unsigned AW = 12 + AVG_LOG2;
    localparam int unsigned CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'((1 << AVG_LOG2) - 1);
    localparam logic [7:0]    WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACC
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [7:0]    wait_cnt;
    logic [11:0]   raw;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;
    logic [CW-1:0] cnt;
    logic          wait_expired;

    // Low nibble of the DRP word carries no result bits.
    logic unused_low_nibble;
    assign unused_low_nibble = ^do_in[3:0];

    assign daddr_out    = DADDR;
    assign acc_sum      = acc + AW'(raw);
    // Last allowed WAIT cycle; drdy in this same cycle still takes priority.
    assign wait_expired = (wait_cnt == WAIT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (eoc_in) next_state = S_REQ;
            S_REQ:  next_state = S_WAIT;
            S_WAIT: begin
                if (drdy_in) begin
                    next_state = S_ACC;
                end else if (wait_expired) begin
                    next_state = S_IDLE;
                end
            end
            S_ACC:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        den_out = (state == S_REQ);
        busy    = (state != S_IDLE);
    end

    // Wait counter, raw capture and timeout pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            raw         <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (state == S_REQ) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                if (drdy_in) begin
                    raw <= do_in[15:4];
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (wait_expired) begin
                        timeout_err <= 1'b1;
                    end
                end
            end
        end
    end

    // Averaging and sample output. With avg_en low the window is held empty,
    // so re-enabling always starts a fresh window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            cnt          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (!avg_en) begin
                acc <= '0;
                cnt <= '0;
                if (state == S_ACC) begin
                    sample_out   <= raw;
                    sample_valid <= 1'b1;
                end
            end else if (state == S_ACC) begin
                if (cnt == CNT_LAST) begin
                    sample_out   <= acc_sum[AVG_LOG2 +: 12];
                    sample_valid <= 1'b1;
                    acc          <= '0;
                    cnt          <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // Overrun counter: any eoc outside IDLE is lost, including the cycle
    // in which the FSM is just returning to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (eoc_in && (state != S_IDLE) && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef XADC_SAMPLER_MINMAX_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_out <= '1;
            max_out <= '0;
        end else if (minmax_clr) begin
            min_out <= '1;
            max_out <= '0;
        end else if (state == S_ACC) begin
            if (raw < min_out) min_out <= raw;
            if (raw > max_out) max_out <= raw;
        end
    end
`endif

endmodule

// File: tb/tb_xadc_drp_sampler.sv
module tb_xadc_drp_sampler;

    localparam int unsigned L  = 2;
    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        eoc;
    logic        drdy;
    logic [15:0] din;
    logic        avg_en;
    logic        den_out;
    logic [6:0]  daddr_out;
    logic [11:0] sample_out;
    logic        sample_valid;
    logic        timeout_err;
    logic [7:0]  drop_cnt;
    logic        busy;
`ifdef XADC_SAMPLER_MINMAX_EN
    logic [11:0] min_out;
    logic [11:0] max_out;
    logic        minmax_clr;
`endif

    always #5 clk = ~clk;

    xadc_drp_sampler #(
        .DADDR   (7'h12),
        .AVG_LOG2(L),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .eoc_in      (eoc),
        .drdy_in     (drdy),
        .do_in       (din),
        .den_out     (den_out),
        .daddr_out   (daddr_out),
        .avg_en      (avg_en),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .timeout_err (timeout_err),
        .drop_cnt    (drop_cnt),
        .busy        (busy)
`ifdef XADC_SAMPLER_MINMAX_EN
        ,
        .min_out     (min_out),
        .max_out     (max_out),
        .minmax_clr  (minmax_clr)
`endif
    );

    int total = 0;
    int bad   = 0;
    int den_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40) $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a read is "in flight" from acceptance
    // until its result is consumed; m_t is the cycle index within the read
    // (0 = request cycle, 1..TO = waiting for drdy).
    bit          m_busy;
    bit          m_have;
    int          m_t;
    logic [11:0] m_raw;
    logic [11:0] m_sample;
    bit          m_valid;
    bit          m_to;
    int          m_drop;
    int          m_sum;
    logic [11:0] win[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_have = 0; m_t = 0; m_raw = '0; m_sample = '0;
            m_valid = 0; m_to = 0; m_drop = 0;
            win.delete();
        end else begin
            m_valid = 0;
            m_to    = 0;
            if (m_busy && eoc && m_drop < 255) m_drop++;
            if (!m_busy) begin
                if (eoc) begin
                    m_busy = 1;
                    m_t    = 0;
                end
            end else if (m_have) begin
                if (avg_en) begin
                    win.push_back(m_raw);
                    if (win.size() == (1 << L)) begin
                        m_sum = 0;
                        foreach (win[i]) m_sum += int'(win[i]);
                        m_sample = 12'(m_sum / (1 << L));
                        m_valid  = 1;
                        win.delete();
                    end
                end else begin
                    m_sample = m_raw;
                    m_valid  = 1;
                end
                m_busy = 0;
                m_have = 0;
            end else if (m_t == 0) begin
                m_t = 1;
            end else if (drdy) begin
                m_raw  = din[15:4];
                m_have = 1;
            end else if (m_t == int'(TO)) begin
                m_busy = 0;
                m_to   = 1;
            end else begin
                m_t++;
            end
            if (!avg_en) win.delete();
        end
    end

    always @(negedge clk) begin
        chk("den",    32'(den_out),      32'(m_busy && !m_have && m_t == 0));
        chk("daddr",  32'(daddr_out),    32'h12);
        chk("busy",   32'(busy),         32'(m_busy));
        chk("valid",  32'(sample_valid), 32'(m_valid));
        chk("tmo",    32'(timeout_err),  32'(m_to));
        chk("drop",   32'(drop_cnt),     32'(m_drop));
        chk("sample", 32'(sample_out),   32'(m_sample));
        if (den_out === 1'b1) den_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One read: eoc, drdy dly cycles after den, result sampled in the cycle
    // where sample_valid would be high.
    task automatic do_read(input logic [15:0] d, input int dly,
                           output logic v, output logic [11:0] s);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        repeat (dly) tick();
        drdy = 1'b1;
        din  = d;
        tick();
        drdy = 1'b0;
        tick();
        v = sample_valid;
        s = sample_out;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    logic        v;
    logic [11:0] s;
    int          den0;

    initial begin
        rst = 1'b1; eoc = 1'b0; drdy = 1'b0; din = '0; avg_en = 1'b0;
`ifdef XADC_SAMPLER_MINMAX_EN
        minmax_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sample", 32'(sample_out), 32'h0);
        chk("rst_busy",   32'(busy),       32'h0);
        chk("rst_drop",   32'(drop_cnt),   32'h0);
        chk("rst_den",    32'(den_out),    32'h0);
        rst = 1'b0;
        tick(); tick();

        // Basic read, drdy 3 cycles after den
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        chk("basic_den", 32'(den_out), 32'h1);
        tick(); tick(); tick();
        drdy = 1'b1; din = 16'hABC0;
        tick();
        drdy = 1'b0;
        chk("basic_v0", 32'(sample_valid), 32'h0);
        tick();
        chk("basic_v1", 32'(sample_valid), 32'h1);
        chk("basic_s",  32'(sample_out),   32'hABC);
        tick();
        chk("basic_v2", 32'(sample_valid), 32'h0);

        // drdy while idle is ignored
        drdy = 1'b1; din = 16'hFFF0;
        tick();
        drdy = 1'b0;
        tick();
        chk("idle_drdy_busy", 32'(busy),         32'h0);
        chk("idle_drdy_v",    32'(sample_valid), 32'h0);

        // drdy on the last allowed WAIT cycle wins over the timeout
        do_read(16'h7770, int'(TO), v, s);
        chk("edge_v", 32'(v), 32'h1);
        chk("edge_s", 32'(s), 32'h777);
        tick();

        // Averaging over four reads
        avg_en = 1'b1;
        tick();
        do_read(16'h1000, 1, v, s); chk("avg_v1", 32'(v), 32'h0);
        do_read(16'h2000, 2, v, s); chk("avg_v2", 32'(v), 32'h0);
        do_read(16'h3000, 1, v, s); chk("avg_v3", 32'(v), 32'h0);
        do_read(16'h4000, 4, v, s);
        chk("avg_v4", 32'(v), 32'h1);
        chk("avg_s",  32'(s), 32'h280);
        tick();
        avg_en = 1'b0;
        tick();

        // Timeout then a normal read
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        repeat (TO) tick();
        chk("tmo_busy", 32'(busy),        32'h1);
        chk("tmo_pre",  32'(timeout_err), 32'h0);
        tick();
        chk("tmo_pulse", 32'(timeout_err),  32'h1);
        chk("tmo_idle",  32'(busy),         32'h0);
        chk("tmo_nov",   32'(sample_valid), 32'h0);
        tick();
        chk("tmo_end", 32'(timeout_err), 32'h0);
        do_read(16'h5A50, 2, v, s);
        chk("post_tmo_v", 32'(v), 32'h1);
        chk("post_tmo_s", 32'(s), 32'h5A5);
        tick();

        // Overrun: three eoc pulses during WAIT
        den0 = den_seen;
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        repeat (3) begin
            eoc = 1'b1; tick();
            eoc = 1'b0; tick();
        end
        drdy = 1'b1; din = 16'h1230;
        tick();
        drdy = 1'b0;
        tick();
        chk("ovr_drop", 32'(drop_cnt),        32'h3);
        chk("ovr_den",  32'(den_seen - den0), 32'h1);
        chk("ovr_s",    32'(sample_out),      32'h123);

        // Saturation with eoc held for many busy cycles
        eoc = 1'b1;
        repeat (320) tick();
        eoc = 1'b0;
        repeat (20) tick();
        chk("sat_drop", 32'(drop_cnt), 32'hFF);

        // Reset asserted in WAIT
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",  32'(busy),         32'h0);
        chk("mid_rst_den",   32'(den_out),      32'h0);
        chk("mid_rst_drop",  32'(drop_cnt),     32'h0);
        chk("mid_rst_samp",  32'(sample_out),   32'h0);
        chk("mid_rst_v",     32'(sample_valid), 32'h0);
        chk("mid_rst_tmo",   32'(timeout_err),  32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Partial window discarded by a one-cycle avg_en drop
        avg_en = 1'b1;
        tick();
        do_read(16'hFFF0, 1, v, s); chk("tog_v1", 32'(v), 32'h0);
        do_read(16'hFFF0, 1, v, s); chk("tog_v2", 32'(v), 32'h0);
        tick();
        avg_en = 1'b0;
        tick();
        avg_en = 1'b1;
        tick();
        do_read(16'h0100, 1, v, s); chk("tog_v3", 32'(v), 32'h0);
        do_read(16'h0200, 3, v, s); chk("tog_v4", 32'(v), 32'h0);
        do_read(16'h0300, 1, v, s); chk("tog_v5", 32'(v), 32'h0);
        do_read(16'h0500, 2, v, s);
        chk("tog_v6", 32'(v), 32'h1);
        chk("tog_s",  32'(s), 32'h02C);
        tick();
        avg_en = 1'b0;

`ifdef XADC_SAMPLER_MINMAX_EN
        minmax_clr = 1'b1;
        tick();
        minmax_clr = 1'b0;
        do_read(16'h1000, 1, v, s);
        do_read(16'h0500, 1, v, s);
        do_read(16'h3000, 1, v, s);
        tick();
        chk("mm_min", 32'(min_out), 32'h050);
        chk("mm_max", 32'(max_out), 32'h300);
        minmax_clr = 1'b1;
        tick();
        minmax_clr = 1'b0;
        chk("mm_clr_min", 32'(min_out), 32'hFFF);
        chk("mm_clr_max", 32'(max_out), 32'h000);
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xadc_drp_sampler.md
Name: xadc_drp_sampler

Overview:
- Front-end stage between the XADC primitive's DRP port and the threshold/compare control logic.
- On each end-of-conversion it issues one DRP read, waits for drdy with a timeout, and extracts the 12-bit result.
- Optionally averages 2^AVG_LOG2 results, then presents a single-cycle-valid sample to the downstream comparator and data register.
- Replaces the direct eoc-to-den tie, so lost or late DRP reads become visible to software.

Parameters:
- DADDR, 7'h12, DRP address read on every request (VAUX2 result register).
- AVG_LOG2, 2, log2 of the averaging window (legal range 0..4; 0 means no averaging).
- TIMEOUT, 15, number of WAIT cycles allowed for drdy before aborting (legal range 1..255).

Ports:
- clk  in  1  system clock, also DRP dclk.
- rst  in  1  asynchronous, active-high reset.
- eoc_in  in  1  end-of-conversion pulse from XADC.
- drdy_in  in  1  DRP data-ready.
- do_in  in  16  DRP read data; result is do_in[15:4].
- den_out  out  1  DRP enable; a one-cycle pulse per request.
- daddr_out  out  7  DRP address, constant DADDR.
- avg_en  in  1  1 = averaged output, 0 = every raw sample output.
- sample_out  out  12  latest raw or averaged result.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- timeout_err  out  1  one-cycle pulse on DRP timeout.
- drop_cnt  out  8  count of eoc_in pulses ignored while busy; saturates at 8'hFF.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE; den_out=0, sample_out=0, sample_valid=0, timeout_err=0, drop_cnt=0, busy=0; accumulator, window count and wait counter cleared. Reset asserted mid-transaction abandons the read, with no valid or error pulse. daddr_out is always DADDR.
- FSM states: IDLE, REQ, WAIT, ACC.
- IDLE: eoc_in=1 moves to REQ at the next edge.
- REQ: den_out=1 for exactly this one cycle; wait counter cleared; next state WAIT.
- WAIT:
  - den_out=0; the wait counter increments every cycle.
  - drdy_in=1: latch raw=do_in[15:4]; go to ACC.
  - Counter reaches TIMEOUT with no drdy: timeout_err=1 for the next cycle; return to IDLE; accumulator untouched.
  - drdy_in and timeout in the same cycle: drdy wins.
- ACC: one cycle, then IDLE.
  - avg_en=0: sample_out<=raw, sample_valid=1.
  - avg_en=1:
    - acc<=acc+raw and cnt<=cnt+1.
    - When cnt==2^AVG_LOG2-1: sample_out<=(acc+raw)>>AVG_LOG2 (truncating), sample_valid=1, acc<=0, cnt<=0.
- Accumulator width is 12+AVG_LOG2 bits, so it never overflows.
- Whenever avg_en=0, acc and cnt are held at 0. A partial window is discarded on avg_en falling, and a fresh window starts on avg_en rising.
- Outputs are registered:
  - sample_valid and timeout_err are high for exactly one cycle.
  - sample_valid is high in the cycle after ACC, i.e. 2 cycles after drdy_in is sampled high.
  - Minimum eoc_in-to-sample_valid latency is 4 cycles (drdy returned 1 cycle after den).
- eoc_in=1 while busy (REQ/WAIT/ACC): no new request is made, and drop_cnt increments (saturating).
- drdy_in outside WAIT is ignored.
- eoc_in in the same cycle the FSM returns to IDLE counts as dropped; eoc is accepted only when state is IDLE.

Optional Feature:
- Macro XADC_SAMPLER_MINMAX_EN.
- Defined:
  - Adds ports min_out[11:0] out, max_out[11:0] out and minmax_clr in.
  - Every raw sample latched in ACC updates min/max, independent of avg_en.
  - Reset values are min_out=12'hFFF and max_out=12'h000.
  - minmax_clr=1 restores the reset values.
  - minmax_clr and a sample in the same cycle: clear wins.
- Not defined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Basic read: avg_en=0; pulse eoc; drdy 3 cycles after den with do_in=16'hABC0 -> one den pulse, daddr_out=7'h12, sample_out=12'hABC, single sample_valid 2 cycles after drdy.
- Averaging: avg_en=1, AVG_LOG2=2; four reads returning 16'h1000, 16'h2000, 16'h3000, 16'h4000 -> sample_valid only after the 4th read, with sample_out=12'h280; acc and cnt back to 0.
- Timeout: TIMEOUT=15; eoc pulse, drdy never returned -> timeout_err pulse after 15 WAIT cycles; no sample_valid; back in IDLE; the next eoc is served normally.
- Overrun: eoc pulses on 3 cycles while in WAIT -> drop_cnt=3, only one den pulse; with 300 such pulses drop_cnt=8'hFF.
- Reset and avg toggle: assert rst in WAIT -> all outputs 0 immediately. After 2 of 4 windowed samples, drop avg_en for one cycle -> the next 4 samples alone determine the average.
- MINMAX (macro on): samples 12'h100, 12'h050, 12'h300 -> min_out=12'h050, max_out=12'h300; pulse minmax_clr -> 12'hFFF / 12'h000.
